serial_adder: RTL and testbench

//   Bit-serial adder: the addition counterpart of the team's subtractor cells.
//   - Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
//   - Adds them LSB-first through a single full-adder cell and a carry flip-flop,
//     one bit per clock.
//   - Holds the WIDTH-bit sum and carry-out on an output valid/ready handshake.
//   - Area-minimal adder for datapaths where latency is cheap.

---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, LSB-first through one full-adder cell and a
//               carry flop, with valid/ready handshakes on input and output.
//               Define SERIAL_ADD_OVF_EN to add the signed-overflow port ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    // Single full-adder cell shared by every bit position
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (cnt == LAST);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    // Counter returns to zero on the last bit instead of wrapping
                    if (last_bit) begin
                        cnt   <= '0;
                        cout  <= c_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB is the flop value on the final edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf <= carry ^ c_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Testbench for serial_adder (WIDTH=8): directed scenarios plus random sums.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic get_ovf();
`ifdef SERIAL_ADD_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Present operands for one accepting edge, then wait for out_valid.
    task automatic start_and_wait(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                  output int lat);
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [7:0] es, input logic ec);
        tests++;
        if (!out_valid || sum !== es || cout !== ec) begin
            fails++;
            $display("FAIL %s: out_valid=%b sum=%h cout=%b, required sum=%h cout=%b",
                     name, out_valid, sum, cout, es, ec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b, required 1 0 00 0",
                     in_ready, out_valid, sum, cout);
        end
        tests++;
        if (get_ovf() !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: ovf=%b, required 0", get_ovf());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        start_and_wait(8'h0F, 8'h01, 1'b0, lat);
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL latency: edges=%0d, required 8", lat);
        end
        check_result("0F+01", 8'h10, 1'b0);
        consume();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        int lat;
        start_and_wait(8'hFF, 8'h01, 1'b0, lat);
        check_result("FF+01", 8'h00, 1'b1);
        consume();
        start_and_wait(8'h00, 8'h00, 1'b1, lat);
        check_result("00+00+1", 8'h01, 1'b0);
        consume();
    endtask

    task automatic test_ovf();
        int lat;
        start_and_wait(8'h7F, 8'h01, 1'b0, lat);
        check_result("7F+01", 8'h80, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_7F+01: ovf=%b, required 1", ovf);
        end
`endif
        consume();
        start_and_wait(8'h80, 8'h80, 1'b0, lat);
        check_result("80+80", 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_80+80: ovf=%b, required 1", ovf);
        end
`endif
        consume();
        start_and_wait(8'h3C, 8'h41, 1'b1, lat);
        check_result("3C+41+1", 8'h7E, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_3C+41: ovf=%b, required 0", ovf);
        end
`endif
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        start_and_wait(8'hA5, 8'h5A, 1'b1, lat);
        check_result("A5+5A+1", 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h00 || cout !== 1'b1) begin
                fails++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b, required 1 0 00 1",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        consume();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_shift_busy: in_ready=%b, required 0", in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(8'h22, 8'h11, 1'b0, lat);
        check_result("22+11", 8'h33, 1'b0);
        consume();
    endtask

    task automatic test_ignore_inputs();
        int lat;
        logic busy_ok;
        @(negedge clk);
        a = 8'h96; b = 8'h3B; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        busy_ok = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            a = ~a; b = b + 8'h17; cin = ~cin; in_valid = ~in_valid;
            if (!out_valid && in_ready !== 1'b0) busy_ok = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        tests++;
        if (!busy_ok) begin
            fails++;
            $display("FAIL busy_in_ready: in_ready went high during shift, required 0");
        end
        check_result("96+3B_toggled", 8'hD1, 1'b0);
        consume();
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp_v;
        logic       exp_o;
        int         bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp_v = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            exp_o = (ra[7] == rb[7]) && (exp_v[7] != ra[7]);
            start_and_wait(ra, rb, rc, lat);
            tests++;
            if (lat != 8 || sum !== exp_v[7:0] || cout !== exp_v[8]
`ifdef SERIAL_ADD_OVF_EN
                || ovf !== exp_o
`endif
                ) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random %h+%h+%b: lat=%0d sum=%h cout=%b ovf=%b, required lat=8 sum=%h cout=%b ovf=%b",
                             ra, rb, rc, lat, sum, cout, get_ovf(), exp_v[7:0], exp_v[8], exp_o);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ovf();
        test_backpressure();
        test_reset_mid_shift();
        test_ignore_inputs();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
